// File: rtl/epp_bram_bridge.sv
// EPP host port bridged to an AW-bit BRAM: address pointer with auto-increment/wrap, data, control/status.
// Define EPP_SEQ_PORT_EN to enable the write-only sequencer data port at register 0x04.
module epp_bram_bridge #(
  parameter int unsigned AW          = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stbAddr,
  input  logic          stbData,
  input  logic          ctrlWr,
  input  logic [7:0]    busEppIn,
  output logic [7:0]    busEppOut,
  output logic          eppWait,
  output logic [AW-1:0] busBramAddr,
  input  logic [7:0]    busBramIn,
  output logic [7:0]    busBramOut,
  output logic          ctrlWeBram,
  output logic          clkBram,
  input  logic          stmBusy,
  output logic          wr_seq,
  output logic [7:0]    dato_seq
);
  localparam int unsigned HW = AW - 8;
  localparam logic [7:0] A_PTR_LO = 8'h00;
  localparam logic [7:0] A_PTR_HI = 8'h01;
  localparam logic [7:0] A_DATA   = 8'h02;
  localparam logic [7:0] A_CTRL   = 8'h03;
`ifdef EPP_SEQ_PORT_EN
  localparam logic [7:0] A_SEQ    = 8'h04;
`endif

  typedef enum logic [2:0] {IDLE, DECODE, BRAM_RD, STALL, ACK} state_t;
  state_t state, nextState;

  logic [SYNC_STAGES-1:0] syncA, syncD;
  logic aLowQ, dLowQ, aLow, dLow, fallA, fallD;
  logic go, curData, collide, incNow;
  logic isData, isRd, stalled;
  logic autoInc, wrapFlag, collision;
  logic [AW-1:0] ptr;
  logic [7:0] eppAddr;

  assign clkBram     = clk;
  assign busBramAddr = ptr;

  // Strobe synchronisers; idle level of the EPP strobes is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA <= '1;
      syncD <= '1;
      aLowQ <= 1'b0;
      dLowQ <= 1'b0;
    end else begin
      syncA <= {syncA[SYNC_STAGES-2:0], stbAddr};
      syncD <= {syncD[SYNC_STAGES-2:0], stbData};
      aLowQ <= aLow;
      dLowQ <= dLow;
    end
  end

  assign aLow  = ~syncA[SYNC_STAGES-1];
  assign dLow  = ~syncD[SYNC_STAGES-1];
  assign fallA = aLow & ~aLowQ;
  assign fallD = dLow & ~dLowQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // go marks the edge on which an access is performed (entry into DECODE)
  always_comb begin
    nextState = state;
    go        = 1'b0;
    curData   = isData;
    collide   = 1'b0;
    case (state)
      IDLE: begin
        if (fallA || fallD) begin
          if (aLow && dLow) begin
            collide = 1'b1;
          end else begin
            go        = 1'b1;
            curData   = dLow;
            nextState = DECODE;
          end
        end
      end
      DECODE: begin
        if (stalled)                                 nextState = STALL;
        else if (isData && isRd && eppAddr == A_DATA) nextState = BRAM_RD;
        else                                          nextState = ACK;
      end
      BRAM_RD: nextState = ACK;
      STALL: begin
        if (!stmBusy) begin
          go        = 1'b1;
          nextState = DECODE;
        end
      end
      ACK: begin
        if (isData ? !dLow : !aLow) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign incNow = autoInc &&
                  ((state == DECODE && !stalled && isData && !isRd && eppAddr == A_DATA) ||
                   state == BRAM_RD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busEppOut  <= 8'h00;
      eppWait    <= 1'b0;
      busBramOut <= 8'h00;
      ctrlWeBram <= 1'b0;
      eppAddr    <= 8'h00;
      ptr        <= '0;
      autoInc    <= 1'b1;
      wrapFlag   <= 1'b0;
      collision  <= 1'b0;
      isData     <= 1'b0;
      isRd       <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      ctrlWeBram <= 1'b0;
      eppWait    <= (nextState == ACK);
      if (collide) collision <= 1'b1;
      if (go) begin
        isData  <= curData;
        isRd    <= ctrlWr;
        stalled <= 1'b0;
        if (!curData) begin
          if (!ctrlWr) eppAddr   <= busEppIn;
          else         busEppOut <= eppAddr;
        end else if (eppAddr == A_DATA && stmBusy) begin
          stalled <= 1'b1;
        end else if (!ctrlWr) begin
          case (eppAddr)
            A_PTR_LO: ptr[7:0]    <= busEppIn;
            A_PTR_HI: ptr[AW-1:8] <= busEppIn[HW-1:0];
            A_DATA: begin
              ctrlWeBram <= 1'b1;
              busBramOut <= busEppIn;
            end
            A_CTRL: begin
              autoInc <= busEppIn[0];
              if (busEppIn[1]) wrapFlag  <= 1'b0;
              if (busEppIn[6]) collision <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          case (eppAddr)
            A_PTR_LO: busEppOut <= ptr[7:0];
            A_PTR_HI: busEppOut <= 8'(ptr[AW-1:8]);
            A_DATA:   ;
            A_CTRL:   busEppOut <= {stmBusy, collision, 4'b0000, wrapFlag, autoInc};
            default:  busEppOut <= 8'h00;
          endcase
        end
      end
      // BRAM data arrives one cycle after the address was presented in DECODE
      if (state == BRAM_RD) busEppOut <= busBramIn;
      if (incNow) begin
        ptr <= ptr + AW'(1);
        if (&ptr) wrapFlag <= 1'b1;
      end
    end
  end

`ifdef EPP_SEQ_PORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_seq   <= 1'b0;
      dato_seq <= 8'h00;
    end else begin
      wr_seq <= 1'b0;
      if (go && curData && !ctrlWr && eppAddr == A_SEQ) begin
        wr_seq   <= 1'b1;
        dato_seq <= busEppIn;
      end
    end
  end
`else
  assign wr_seq   = 1'b0;
  assign dato_seq = 8'h00;
`endif

endmodule
